// File: rtl/burst_do_gen.sv
// Command stage for the run/last controller: turns a burst-length command into
// exactly that many cycles of run request, followed by a guaranteed low gap.
module burst_do_gen #(
    parameter int LEN_W   = 8,
    parameter int GAP_MIN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
    output logic             burst_do,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int GAP_W = $clog2(GAP_MIN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [LEN_W-1:0]   len_cnt, len_n;
    logic [GAP_W-1:0]   gap_cnt, gap_n;
    logic               aborted_r, aborted_r_n;
    logic               do_n, busy_n, done_n, aborted_n;

    // The downstream controller needs its `do` glitch-free, so it is a register.
    // The name burst_do is used because `do` is a reserved word.
    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_cnt   <= '0;
            gap_cnt   <= '0;
            aborted_r <= 1'b0;
            burst_do  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_n;
            len_cnt   <= len_n;
            gap_cnt   <= gap_n;
            aborted_r <= aborted_r_n;
            burst_do  <= do_n;
            busy      <= busy_n;
            done      <= done_n;
            aborted   <= aborted_n;
        end
    end

    // Outputs are computed one cycle ahead, so each reflects the state being entered.
    always_comb begin
        state_n     = state;
        len_n       = len_cnt;
        gap_n       = gap_cnt;
        aborted_r_n = aborted_r;
        do_n        = 1'b0;
        busy_n      = 1'b0;
        done_n      = 1'b0;
        aborted_n   = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        state_n = BURST;
                        len_n   = cmd_len;
                        do_n    = 1'b1;
                        busy_n  = 1'b1;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end

            BURST: begin
                busy_n = 1'b1;
                if (abort) begin
                    state_n     = GAP;
                    gap_n       = GAP_W'(GAP_MIN);
                    aborted_r_n = 1'b1;
                end else if (len_cnt == LEN_W'(1)) begin
                    state_n     = GAP;
                    gap_n       = GAP_W'(GAP_MIN);
                    aborted_r_n = 1'b0;
                end else begin
                    len_n = len_cnt - LEN_W'(1);
                    do_n  = 1'b1;
                end
            end

            GAP: begin
                if (gap_cnt == GAP_W'(1)) begin
                    state_n   = IDLE;
                    done_n    = 1'b1;
                    aborted_n = aborted_r;
                end else begin
                    gap_n  = gap_cnt - GAP_W'(1);
                    busy_n = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_burst_do_gen.sv
// Directed bench for burst_do_gen: a per-cycle vector table plus hand-written
// sequences for the maximum-length burst and an asynchronous reset mid-burst.
module tb_burst_do_gen;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_len;
    logic       abort;
    logic       burst_do;
    logic       busy;
    logic       done;
    logic       aborted;

    int total_checks;
    int passed_checks;

    typedef struct {
        logic       valid;
        logic [7:0] len;
        logic       ab;
        logic [4:0] expect_out;
    } vec_t;

    vec_t vecs[$];

    burst_do_gen #(.LEN_W(8), .GAP_MIN(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .abort     (abort),
        .burst_do  (burst_do),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] outs();
        return {burst_do, busy, done, aborted, cmd_ready};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        total_checks++;
        if (actual !== required)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
        else
            passed_checks++;
    endtask

    task automatic add(input logic v, input logic [7:0] len, input logic ab, input logic [4:0] e);
        vec_t t;
        t.valid      = v;
        t.len        = len;
        t.ab         = ab;
        t.expect_out = e;
        vecs.push_back(t);
    endtask

    // Drive inputs for one edge and compare {do,busy,done,aborted,ready} after it.
    task automatic step(input logic v, input logic [7:0] len, input logic ab,
                        input logic [4:0] e, input string name);
        cmd_valid = v;
        cmd_len   = len;
        abort     = ab;
        @(posedge clk);
        #1;
        check(name, 32'(outs()), 32'(e));
    endtask

    initial begin
        int do_count;
        int done_cycle;
        logic ab_seen;

        total_checks  = 0;
        passed_checks = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = 8'd0;
        abort     = 1'b0;

        // Length 5: do cycles 1-5, gap 6-7, done in 8.
        add(1, 8'd5, 0, 5'b11000);
        add(0, 8'd0, 0, 5'b11000);
        add(0, 8'd0, 0, 5'b11000);
        add(0, 8'd0, 0, 5'b11000);
        add(0, 8'd0, 0, 5'b11000);
        add(0, 8'd0, 0, 5'b01000);
        add(0, 8'd0, 0, 5'b01000);
        add(0, 8'd0, 0, 5'b00101);
        add(0, 8'd0, 0, 5'b00001);
        // Length 3 with a second command (length 2) held valid throughout.
        add(1, 8'd3, 0, 5'b11000);
        add(1, 8'd2, 0, 5'b11000);
        add(1, 8'd2, 0, 5'b11000);
        add(1, 8'd2, 0, 5'b01000);
        add(1, 8'd2, 0, 5'b01000);
        add(1, 8'd2, 0, 5'b00101);
        add(1, 8'd2, 0, 5'b11000);
        add(0, 8'd0, 0, 5'b11000);
        add(0, 8'd0, 0, 5'b01000);
        add(0, 8'd0, 0, 5'b01000);
        add(0, 8'd0, 0, 5'b00101);
        add(0, 8'd0, 0, 5'b00001);
        // Length 10 aborted in the 4th do cycle; aborts during the gap are ignored.
        add(1, 8'd10, 0, 5'b11000);
        add(0, 8'd0, 0, 5'b11000);
        add(0, 8'd0, 0, 5'b11000);
        add(0, 8'd0, 0, 5'b11000);
        add(0, 8'd0, 1, 5'b01000);
        add(0, 8'd0, 1, 5'b01000);
        add(0, 8'd0, 1, 5'b00111);
        add(0, 8'd0, 0, 5'b00001);
        // Abort in the final burst cycle still reports aborted.
        add(1, 8'd2, 0, 5'b11000);
        add(0, 8'd0, 0, 5'b11000);
        add(0, 8'd0, 1, 5'b01000);
        add(0, 8'd0, 0, 5'b01000);
        add(0, 8'd0, 0, 5'b00111);
        // Zero-length commands back to back, then abort while idle.
        add(1, 8'd0, 0, 5'b00101);
        add(1, 8'd0, 0, 5'b00101);
        add(0, 8'd0, 0, 5'b00001);
        add(0, 8'd0, 1, 5'b00001);
        // Single-cycle burst.
        add(1, 8'd1, 0, 5'b11000);
        add(0, 8'd0, 0, 5'b01000);
        add(0, 8'd0, 0, 5'b01000);
        add(0, 8'd0, 0, 5'b00101);
        add(0, 8'd0, 0, 5'b00001);

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(outs()), 32'(5'b00001));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", 32'(outs()), 32'(5'b00001));

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].valid, vecs[i].len, vecs[i].ab, vecs[i].expect_out,
                 $sformatf("vec%0d", i));

        // Maximum length burst: 255 do cycles, done in cycle 258.
        cmd_valid = 1'b1;
        cmd_len   = 8'd255;
        abort     = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_len    = 8'd0;
        do_count   = 0;
        done_cycle = 0;
        ab_seen    = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (burst_do) do_count++;
            if (done) begin
                done_cycle = c;
                ab_seen    = aborted;
                break;
            end
        end
        check("max_len_do_cycles", 32'(do_count), 32'd255);
        check("max_len_done_cycle", 32'(done_cycle), 32'd258);
        check("max_len_aborted", 32'(ab_seen), 32'd0);
        step(0, 8'd0, 0, 5'b00001, "max_len_after");

        // Asynchronous reset in cycle 3 of a 6-cycle burst.
        step(1, 8'd6, 0, 5'b11000, "rst_burst_c1");
        step(0, 8'd0, 0, 5'b11000, "rst_burst_c2");
        step(0, 8'd0, 0, 5'b11000, "rst_burst_c3");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_drop", 32'(outs()), 32'(5'b00001));
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 8'd0, 0, 5'b00001, "post_reset_idle");
        step(1, 8'd2, 0, 5'b11000, "post_reset_c1");
        step(0, 8'd0, 0, 5'b11000, "post_reset_c2");
        step(0, 8'd0, 0, 5'b01000, "post_reset_gap1");
        step(0, 8'd0, 0, 5'b01000, "post_reset_gap2");
        step(0, 8'd0, 0, 5'b00101, "post_reset_done");
        step(0, 8'd0, 0, 5'b00001, "post_reset_idle2");

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/burst_do_gen.md
Name: burst_do_gen

Overview:
- Upstream command stage for the comb-onTransit run/last controller; its registered `do` output drives that FSM's `do` input directly.
- Accepts a burst-length command over a valid/ready handshake and holds `do` high for exactly that many cycles.
- Then enforces a minimum low gap so the downstream FSM can pass RUN->LAST->IDLE before the next burst.
- Reports completion with a one-cycle `done` pulse and flags bursts truncated by `abort`.

Parameters:
- LEN_W, 8, width of cmd_len and the internal burst counter.
- GAP_MIN, 2, number of forced `do`-low cycles after each burst. Must be >= 2; the downstream LAST state ignores `do`.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_len  input  LEN_W  burst length in cycles, sampled on handshake
- abort  input  1  truncate the active burst
- do  output  1  run request to the downstream controller (registered)
- busy  output  1  high in BURST or GAP (registered)
- done  output  1  one-cycle pulse when a command has fully retired (registered)
- aborted  output  1  valid with done: the retired burst was truncated (registered)

Behaviour:
- Reset: one clock domain. Reset is asynchronous and active-low (rst_n); clk/rst_n naming and polarity are fixed.
- Reset values: state=IDLE, do=0, busy=0, done=0, aborted=0, len_cnt=0, gap_cnt=0. cmd_ready=1, decoded from state.
- Reset mid-burst: `do` drops immediately (async). No done pulse is generated.
- cmd_ready = (state==IDLE). It decodes only the state register and never depends on inputs in the same cycle.
- Handshake: accept occurs at a rising edge with cmd_valid & cmd_ready. cmd_len is sampled at that edge. cmd_valid may drop at any time without effect until accepted.
- State machine, IDLE:
  - accept with cmd_len!=0 -> BURST; len_cnt=cmd_len, do=1, busy=1.
  - accept with cmd_len==0 -> stay IDLE; done=1 with aborted=0 next cycle; do stays 0.
- State machine, BURST:
  - do=1 each cycle; len_cnt decrements per cycle.
  - When len_cnt==1 and no abort -> GAP; do=0, gap_cnt=GAP_MIN, aborted_r=0.
  - abort=1 in any BURST cycle -> GAP next edge; do=0, gap_cnt=GAP_MIN, aborted_r=1.
  - abort in the final BURST cycle still sets aborted_r=1.
- State machine, GAP:
  - do=0, busy=1; gap_cnt decrements.
  - When gap_cnt==1 -> IDLE; done=1 and aborted=aborted_r for that one cycle; busy=0.
- abort is ignored in IDLE and GAP.
- Timing for a command accepted at edge k with length L (no abort):
  - do is high during cycles k+1..k+L, exactly L cycles.
  - GAP occupies k+L+1..k+L+GAP_MIN.
  - done=1 and cmd_ready=1 in cycle k+L+GAP_MIN+1.
- Back-to-back: a command held valid is accepted at the edge ending the done cycle. Minimum do-low run between bursts is therefore GAP_MIN+1 cycles.
- done is the only pulse and never asserts for two consecutive cycles, except for consecutive zero-length commands.
- Counter width: len_cnt is LEN_W bits. Maximum burst is 2^LEN_W-1 cycles with no wrap, since the counter never decrements below 1 in BURST.
- Downstream contract: with the comb-onTransit FSM fed by `do`, each burst of L yields exactly L-1 `s` pulses and one `g` pulse. A new burst always starts from downstream IDLE.

Test Plan:
- Reset then cmd_len=5 accepted at edge 0 -> do=1 in cycles 1-5, busy 1-7, done=1 in cycle 8 with aborted=0. Downstream sees s=1 four times and g=1 once.
- cmd_len=3 with cmd_valid held for a second command cmd_len=2 -> second accept on the done cycle. do-low run between bursts is exactly 3 cycles; two done pulses.
- cmd_len=10, abort=1 in the 4th do-high cycle -> do high for 4 cycles only, done after 2 GAP cycles with aborted=1. Abort pulses during the GAP have no effect.
- cmd_len=0 accepted -> do never rises, busy stays 0, done=1 next cycle with aborted=0, cmd_ready stays 1.
- LEN_W=8, cmd_len=255 -> exactly 255 do-high cycles, no counter wrap, done at cycle 258.
- rst_n asserted asynchronously mid-BURST (cycle 3 of 6) -> do, busy, done drop immediately; after release cmd_ready=1 and a new cmd_len=2 runs normally.
